// File: rtl/odelay_bank_ramp.sv
// Ramp controller for a bank of fine-delay output delay elements: walks every channel
// toward its target code in lockstep steps of at most MAX_STEP taps, each step being a value/LDPIPEEN/LD sequence.
module odelay_bank_ramp #(
  parameter int          NUM_CH      = 8,
  parameter logic [7:0]  DELAY_VALUE = 8'h00,
  parameter int          MAX_STEP    = 10,
  localparam int         AW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_bcast,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  apply,
  input  logic                  clr_err,
  output logic                  busy,
  output logic                  done,
  output logic                  clamp_err,
  output logic                  wr_reject,
  output logic [NUM_CH*5-1:0]   dly_coarse,
  output logic [NUM_CH*3-1:0]   dly_fine,
  output logic                  dly_ldpipe,
  output logic                  dly_ld,
  output logic [NUM_CH*8-1:0]   cur_delay
);

  localparam logic [7:0] RST_CODE = (DELAY_VALUE[2:0] > 3'd4) ? {DELAY_VALUE[7:3], 3'd4} : DELAY_VALUE;
  localparam logic [7:0] STEP     = 8'(MAX_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_LOADPIPE,
    S_SET,
    S_DONE
  } state_t;

  function automatic logic [7:0] f_clamp(input logic [7:0] code);
    f_clamp = (code[2:0] > 3'd4) ? {code[7:3], 3'd4} : code;
  endfunction

  function automatic logic [7:0] f_lin(input logic [7:0] code);
    f_lin = 8'(code[7:3]) * 8'd5 + 8'(code[2:0]);
  endfunction

  // Constant divide by 5; the remainder is always 0..4 so it fits the fine field.
  function automatic logic [7:0] f_enc(input logic [7:0] lin);
    logic [4:0] q;
    q     = 5'(lin / 8'd5);
    f_enc = {q, 3'(lin - 8'(q) * 8'd5)};
  endfunction

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_ldpipe;
  logic                r_ld;
  logic                r_clamp_err;
  logic                r_wr_reject;

  logic                w_idle;
  logic                w_calc;
  logic                w_set;
  logic                w_all_eq;
  logic                w_fine_bad;
  logic [NUM_CH-1:0]   w_eq;

  assign w_idle     = (r_state == S_IDLE);
  assign w_calc     = (r_state == S_CALC);
  assign w_set      = (r_state == S_SET);
  assign w_all_eq   = &w_eq;
  assign w_fine_bad = (wr_data[2:0] > 3'd4);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] r_tgt;
      logic [7:0] r_cur;
      logic [7:0] r_dly;
      logic [7:0] w_tgt_lin;
      logic [7:0] w_cur_lin;
      logic [7:0] w_next_lin;
      logic       w_sel;

      // Out-of-range addresses match no channel; broadcast ignores the address.
      assign w_sel     = wr_en && (wr_bcast || (wr_addr == AW'(gi)));
      assign w_tgt_lin = f_lin(r_tgt);
      assign w_cur_lin = f_lin(r_cur);
      assign w_eq[gi]  = (r_tgt == r_cur);

      always_comb begin
        w_next_lin = w_tgt_lin;
        if (w_tgt_lin > w_cur_lin) begin
          if ((w_tgt_lin - w_cur_lin) > STEP) w_next_lin = w_cur_lin + STEP;
        end else if ((w_cur_lin - w_tgt_lin) > STEP) begin
          w_next_lin = w_cur_lin - STEP;
        end
      end

      // r_dly is the value presented to the primitive; it only moves on entry to
      // LOADPIPE so it is stable across both strobes, and becomes cur on SET.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_tgt <= RST_CODE;
          r_cur <= RST_CODE;
          r_dly <= RST_CODE;
        end else begin
          if (w_idle && w_sel) r_tgt <= f_clamp(wr_data);
          if (w_calc && !w_all_eq) r_dly <= f_enc(w_next_lin);
          if (w_set) r_cur <= r_dly;
        end
      end

      assign dly_coarse[gi*5 +: 5] = r_dly[7:3];
      assign dly_fine[gi*3 +: 3]   = r_dly[2:0];
      assign cur_delay[gi*8 +: 8]  = r_cur;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ldpipe    <= 1'b0;
      r_ld        <= 1'b0;
      r_clamp_err <= 1'b0;
      r_wr_reject <= 1'b0;
    end else begin
      // A new error in the same cycle as clr_err wins.
      r_clamp_err <= (r_clamp_err && !clr_err) || (w_idle && wr_en && w_fine_bad);
      r_wr_reject <= (r_wr_reject && !clr_err) || (!w_idle && wr_en);
      r_done      <= 1'b0;
      r_ldpipe    <= 1'b0;
      r_ld        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (apply) begin
            r_state <= S_CALC;
            r_busy  <= 1'b1;
          end
        end
        S_CALC: begin
          if (w_all_eq) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state  <= S_LOADPIPE;
            r_ldpipe <= 1'b1;
          end
        end
        S_LOADPIPE: begin
          r_state <= S_SET;
          r_ld    <= 1'b1;
        end
        S_SET: begin
          r_state <= S_CALC;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign dly_ldpipe = r_ldpipe;
  assign dly_ld     = r_ld;
  assign clamp_err  = r_clamp_err;
  assign wr_reject  = r_wr_reject;

endmodule

// File: tb/tb_odelay_bank_ramp.sv
// Directed bench for odelay_bank_ramp: table of ramp scenarios plus hand sequences for
// flag handling, rejected writes, a one-step downward ramp and reset mid-ramp.
module tb_odelay_bank_ramp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        wr_bcast = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        apply = 1'b0;
  logic        clr_err = 1'b0;
  logic        sel_b = 1'b0;

  always #5 clk = ~clk;

  // Unit A: DELAY_VALUE 0F, step 10.  Unit B: DELAY_VALUE 00, step 159.
  logic        a_wr_en, a_apply, a_clr, b_wr_en, b_apply, b_clr;
  logic        a_busy, a_done, a_clamp, a_rej, a_ldpipe, a_ld;
  logic        b_busy, b_done, b_clamp, b_rej, b_ldpipe, b_ld;
  logic [39:0] a_coarse, b_coarse;
  logic [23:0] a_fine, b_fine;
  logic [63:0] a_cur, b_cur;

  assign a_wr_en = wr_en & ~sel_b;
  assign a_apply = apply & ~sel_b;
  assign a_clr   = clr_err & ~sel_b;
  assign b_wr_en = wr_en & sel_b;
  assign b_apply = apply & sel_b;
  assign b_clr   = clr_err & sel_b;

  odelay_bank_ramp #(.NUM_CH(8), .DELAY_VALUE(8'h0F), .MAX_STEP(10)) u_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_bcast(wr_bcast), .wr_addr(wr_addr),
    .wr_data(wr_data), .apply(a_apply), .clr_err(a_clr), .busy(a_busy), .done(a_done),
    .clamp_err(a_clamp), .wr_reject(a_rej), .dly_coarse(a_coarse), .dly_fine(a_fine),
    .dly_ldpipe(a_ldpipe), .dly_ld(a_ld), .cur_delay(a_cur)
  );

  odelay_bank_ramp #(.NUM_CH(8), .DELAY_VALUE(8'h00), .MAX_STEP(159)) u_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_bcast(wr_bcast), .wr_addr(wr_addr),
    .wr_data(wr_data), .apply(b_apply), .clr_err(b_clr), .busy(b_busy), .done(b_done),
    .clamp_err(b_clamp), .wr_reject(b_rej), .dly_coarse(b_coarse), .dly_fine(b_fine),
    .dly_ldpipe(b_ldpipe), .dly_ld(b_ld), .cur_delay(b_cur)
  );

  logic        m_busy, m_done, m_clamp, m_rej, m_ldpipe, m_ld;
  logic [39:0] m_coarse;
  logic [23:0] m_fine;
  logic [63:0] m_cur;
  assign m_busy   = sel_b ? b_busy   : a_busy;
  assign m_done   = sel_b ? b_done   : a_done;
  assign m_clamp  = sel_b ? b_clamp  : a_clamp;
  assign m_rej    = sel_b ? b_rej    : a_rej;
  assign m_ldpipe = sel_b ? b_ldpipe : a_ldpipe;
  assign m_ld     = sel_b ? b_ld     : a_ld;
  assign m_coarse = sel_b ? b_coarse : a_coarse;
  assign m_fine   = sel_b ? b_fine   : a_fine;
  assign m_cur    = sel_b ? b_cur    : a_cur;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit         wr;
    bit         bcast;
    int         ch;
    logic [7:0] data;
    bit         same;
    int         start;
    int         exp_pairs;
    int         exp_lat;
    logic [7:0] exp_code;
    bit         exp_clamp;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] m_code[8];
  int         traj[$];
  int         r_lat, r_pairs, r_lds, r_busy;

  function automatic int lin_of(input logic [7:0] c);
    return int'(c[7:3]) * 5 + int'(c[2:0]);
  endfunction

  function automatic logic [7:0] clampc(input logic [7:0] c);
    if (c[2:0] > 3'd4) return {c[7:3], 3'd4};
    return c;
  endfunction

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic write1(input bit bcast, input int ch, input logic [7:0] data);
    wr_en = 1'b1; wr_bcast = bcast; wr_addr = 3'(ch); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0; wr_bcast = 1'b0;
  endtask

  // Optional write, then apply; runs to done recording strobes and channel ch's trajectory.
  task automatic ramp(input bit do_wr, input bit bcast, input int ch, input logic [7:0] data,
                      input bit same, input int inj, input logic [7:0] inj_data);
    int c;
    bit prev_pipe;
    logic [7:0] cv, pipe_val;
    traj.delete();
    r_lat = -1; r_pairs = 0; r_lds = 0; r_busy = 0;
    pipe_val = 8'd0;
    if (do_wr && !same) write1(bcast, ch, data);
    if (do_wr && same) begin
      wr_en = 1'b1; wr_bcast = bcast; wr_addr = 3'(ch); wr_data = data;
    end
    apply = 1'b1;
    @(negedge clk);
    apply = 1'b0; wr_en = 1'b0; wr_bcast = 1'b0;
    c = 1;
    prev_pipe = 1'b0;
    while (r_lat < 0 && c <= 200) begin
      cv = {m_coarse[ch*5 +: 5], m_fine[ch*3 +: 3]};
      if (m_busy) r_busy++;
      if (m_ldpipe) begin
        r_pairs++;
        pipe_val = cv;
        traj.push_back(lin_of(cv));
      end
      if (m_ld) begin
        r_lds++;
        check("ld_follows_ldpipe", int'(prev_pipe), 1);
        check("dly_stable_at_ld", int'(cv), int'(pipe_val));
      end
      if (m_done) r_lat = c;
      prev_pipe = m_ldpipe;
      if (c == inj) begin
        wr_en = 1'b1; wr_addr = 3'(ch); wr_data = inj_data; apply = 1'b1;
      end else begin
        wr_en = 1'b0; apply = 1'b0;
      end
      if (r_lat < 0) begin
        @(negedge clk);
        c++;
      end
    end
    wr_en = 1'b0; apply = 1'b0;
    check("done_seen", int'(r_lat >= 0), 1);
    check("ld_count", r_lds, r_pairs);
    @(negedge clk);
    check("busy_after_done", int'(m_busy), 0);
    check("done_one_cycle", int'(m_done), 0);
    $display("ramp ch=%0d data=%h lat=%0d pairs=%0d busy=%0d", ch, data, r_lat, r_pairs, r_busy);
  endtask

  // Expected walk: move toward target by at most step per pair.
  task automatic check_traj(input int start, input int tgt, input int step);
    int m, k;
    m = start; k = 0;
    while (m != tgt && k < 40) begin
      if (tgt > m) m = (tgt - m <= step) ? tgt : m + step;
      else         m = (m - tgt <= step) ? tgt : m - step;
      if (k < traj.size()) check($sformatf("traj[%0d]", k), traj[k], m);
      k++;
    end
    check("traj_len", traj.size(), k);
  endtask

  initial begin
    logic [63:0] v;
    int k;

    tbl[0] = '{1, 1, 0, 8'h00, 0,   9,  1,  5, 8'h00, 0};
    tbl[1] = '{1, 0, 2, 8'hA3, 0,   0, 11, 35, 8'hA3, 0};
    tbl[2] = '{0, 0, 2, 8'h00, 0, 103,  0,  2, 8'hA3, 0};
    tbl[3] = '{1, 0, 5, 8'h2A, 1,   0,  3, 11, 8'h2A, 0};
    tbl[4] = '{1, 0, 2, 8'h51, 0, 103,  6, 20, 8'h51, 0};
    tbl[5] = '{1, 0, 7, 8'h0D, 1,   0,  1,  5, 8'h0C, 1};
    for (int i = 0; i < 8; i++) m_code[i] = 8'h0C;

    // Reset values with DELAY_VALUE 0F (fine clamped to 4).
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'h0C;
    check64("rst_cur_delay", m_cur, v);
    v = '0;
    for (int i = 0; i < 8; i++) v[i*5 +: 5] = 5'd1;
    check64("rst_coarse", 64'(m_coarse), v);
    v = '0;
    for (int i = 0; i < 8; i++) v[i*3 +: 3] = 3'd4;
    check64("rst_fine", 64'(m_fine), v);
    check("rst_busy", int'(m_busy), 0);
    check("rst_done", int'(m_done), 0);
    check("rst_ldpipe", int'(m_ldpipe), 0);
    check("rst_ld", int'(m_ld), 0);
    check("rst_clamp", int'(m_clamp), 0);
    check("rst_reject", int'(m_rej), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(m_busy), 0);

    // Table-driven ramps on unit A.
    for (int i = 0; i < 6; i++) begin
      pulse_clr();
      if (tbl[i].wr) begin
        if (tbl[i].bcast) for (int j = 0; j < 8; j++) m_code[j] = clampc(tbl[i].data);
        else m_code[tbl[i].ch] = clampc(tbl[i].data);
      end
      ramp(tbl[i].wr, tbl[i].bcast, tbl[i].ch, tbl[i].data, tbl[i].same, -1, 8'h00);
      check($sformatf("v%0d_lat", i), r_lat, tbl[i].exp_lat);
      check($sformatf("v%0d_pairs", i), r_pairs, tbl[i].exp_pairs);
      check($sformatf("v%0d_busy_cycles", i), r_busy, tbl[i].exp_lat);
      check($sformatf("v%0d_code", i), int'(m_cur[tbl[i].ch*8 +: 8]), int'(tbl[i].exp_code));
      check($sformatf("v%0d_clamp", i), int'(m_clamp), int'(tbl[i].exp_clamp));
      for (int j = 0; j < 8; j++) v[j*8 +: 8] = m_code[j];
      check64($sformatf("v%0d_all_cur", i), m_cur, v);
      check_traj(tbl[i].start, lin_of(tbl[i].exp_code), 10);
    end

    // Clamp flag: set by broadcast 07, cleared by clr_err, set-wins when both coincide.
    pulse_clr();
    check("clamp_cleared", int'(m_clamp), 0);
    write1(1'b1, 0, 8'h07);
    check("bcast_clamp_set", int'(m_clamp), 1);
    pulse_clr();
    check("clr_err_clears", int'(m_clamp), 0);
    clr_err = 1'b1;
    write1(1'b0, 4, 8'h0F);
    clr_err = 1'b0;
    check("clr_and_err_same_cycle", int'(m_clamp), 1);
    write1(1'b1, 0, 8'h07);
    ramp(1'b0, 1'b0, 2, 8'h00, 1'b0, -1, 8'h00);
    check64("bcast_all_04", m_cur, {8{8'h04}});
    check("bcast_lat", r_lat, 17);
    check_traj(51, 4, 10);

    // Write and second apply during a ramp are both dropped.
    pulse_clr();
    check("reject_clear", int'(m_rej), 0);
    ramp(1'b1, 1'b0, 1, 8'h50, 1'b0, 3, 8'h10);
    check("reject_set", int'(m_rej), 1);
    check("reject_lat", r_lat, 17);
    check("reject_pairs", r_pairs, 5);
    check("reject_ch1", int'(m_cur[15:8]), 8'h50);
    repeat (3) @(negedge clk);
    check("no_second_ramp", int'(m_busy), 0);
    ramp(1'b0, 1'b0, 1, 8'h00, 1'b0, -1, 8'h00);
    check("target_unchanged_lat", r_lat, 2);
    check("target_unchanged_pairs", r_pairs, 0);

    // One-step downward ramp on unit B (step 159).
    sel_b = 1'b1;
    @(negedge clk);
    ramp(1'b1, 1'b0, 0, 8'hF8, 1'b0, -1, 8'h00);
    check("b_up_ch0", int'(m_cur[7:0]), 8'hF8);
    ramp(1'b1, 1'b0, 0, 8'h00, 1'b0, -1, 8'h00);
    check("b_down_ch0", int'(m_cur[7:0]), 8'h00);
    check("b_down_pairs", r_pairs, 1);
    check("b_down_lat", r_lat, 5);
    check_traj(155, 0, 159);
    sel_b = 1'b0;
    @(negedge clk);

    // Reset asserted during LOADPIPE.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h80; apply = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; apply = 1'b0;
    k = 0;
    while (!m_ldpipe && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("reached_loadpipe", int'(m_ldpipe), 1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'h0C;
    check64("midrst_cur", m_cur, v);
    check("midrst_coarse3", int'(m_coarse[19:15]), 1);
    check("midrst_fine3", int'(m_fine[11:9]), 4);
    check("midrst_ldpipe", int'(m_ldpipe), 0);
    check("midrst_busy", int'(m_busy), 0);
    check("midrst_reject", int'(m_rej), 0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", int'(m_done), 0);
      check("midrst_no_ld", int'(m_ld), 0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("postrst_no_done", int'(m_done), 0);
      check("postrst_idle", int'(m_busy), 0);
    end
    ramp(1'b0, 1'b0, 3, 8'h00, 1'b0, -1, 8'h00);
    check("postrst_noop_lat", r_lat, 2);
    check("postrst_noop_pairs", r_pairs, 0);
    ramp(1'b1, 1'b0, 3, 8'h28, 1'b0, -1, 8'h00);
    check("postrst_lat", r_lat, 8);
    check("postrst_ch3", int'(m_cur[31:24]), 8'h28);
    check_traj(9, 25, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
